// File: rtl/koala_arb_pkg.sv
// Shared types and one-hot helpers for the packet round-robin arbiter family.
// Helpers work on a fixed maximum width; callers zero-extend and size-cast.
package koala_arb_pkg;

   localparam int unsigned ARB_MAX_REQ = 32;
   localparam int unsigned ARB_MAX_IDX_W = 5;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // Rotate a one-hot vector left by one inside an n-bit ring.
   function automatic logic [ARB_MAX_REQ-1:0] rotl1_oh(input logic [ARB_MAX_REQ-1:0] vec,
                                                       input int unsigned n);
      logic [ARB_MAX_REQ-1:0]   res;
      logic [ARB_MAX_IDX_W-1:0] dst;
      res = '0;
      for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
         dst = ARB_MAX_IDX_W'((i + 1) % n);
         if (i < n && vec[i]) res[dst] = 1'b1;
      end
      return res;
   endfunction

   function automatic logic [ARB_MAX_IDX_W-1:0] oh2idx(input logic [ARB_MAX_REQ-1:0] vec);
      logic [ARB_MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
         if (vec[i]) idx = idx | ARB_MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick_core.sv
// Combinational round-robin pick: first set bit of req at or above the one-hot
// pri bit, wrapping; a double-width subtract keeps it to a single carry chain.
module rr_pick_core #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] pri,
   output logic [N-1:0] grant
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] hit;

   assign dbl   = {req, req};
   // The borrow stops at the first request at or above pri; the upper copy covers wrap.
   assign hit   = dbl & ~(dbl - {{N{1'b0}}, pri});
   assign grant = hit[N-1:0] | hit[2*N-1:N];

endmodule

// File: rtl/rr_pkt_arb.sv
// Packet-level round-robin arbiter: a grant stays locked until the owner's last
// beat transfers, then re-arbitrates in the same cycle with zero bubble.
//
// state    | meaning
// ARB_IDLE | no owner; registered pick among eligible requesters
// ARB_BUSY | gnt_q owns the port until its last beat transfers
module rr_pkt_arb
   import koala_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 8,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  logic [NUM_REQ-1:0] req_last_i,
   input  logic [NUM_REQ-1:0] req_mask_i,
   output logic [NUM_REQ-1:0] req_ready_o,
   output logic               gnt_valid_o,
   output logic [NUM_REQ-1:0] gnt_oh_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   input  logic               gnt_ready_i
);

   arb_state_e         state_q;
   logic [NUM_REQ-1:0] pri_q;
   logic [NUM_REQ-1:0] gnt_q;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] pick_idle;
   logic [NUM_REQ-1:0] pick_next;
   logic [NUM_REQ-1:0] pri_rot;
   logic               busy;
   logic               last_xfer;

   assign elig    = req_valid_i & req_mask_i;
   assign busy    = (state_q == ARB_BUSY);
   assign pri_rot = NUM_REQ'(rotl1_oh(ARB_MAX_REQ'(gnt_q), NUM_REQ));

   rr_pick_core #(.N(NUM_REQ)) u_pick_idle (
      .req   (elig),
      .pri   (pri_q),
      .grant (pick_idle)
   );

   // The finishing owner is excluded so it cannot re-win in its own last cycle.
   rr_pick_core #(.N(NUM_REQ)) u_pick_next (
      .req   (elig & ~gnt_q),
      .pri   (pri_rot),
      .grant (pick_next)
   );

   // Reset gates the handshake so nothing transfers in the reset cycle.
   assign req_ready_o = (busy && !rst_i) ? (gnt_q & {NUM_REQ{gnt_ready_i}}) : '0;
   assign gnt_valid_o = busy && !rst_i && |(req_valid_i & gnt_q);
   assign last_xfer   = busy && |(req_valid_i & req_ready_o & req_last_i);

   assign gnt_oh_o  = gnt_q;
   assign gnt_idx_o = IDX_W'(oh2idx(ARB_MAX_REQ'(gnt_q)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         pri_q   <= NUM_REQ'(1);
         gnt_q   <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (|elig) begin
                  gnt_q   <= pick_idle;
                  state_q <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (last_xfer) begin
                  pri_q   <= pri_rot;
                  gnt_q   <= pick_next;
                  state_q <= (|pick_next) ? ARB_BUSY : ARB_IDLE;
               end
            end
            default: begin
               state_q <= ARB_IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

   a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_q));
   a_pri_onehot  : assert property (@(posedge clk_i) disable iff (rst_i) $onehot(pri_q));
   a_rdy_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_ready_o));
   a_idle_no_rdy : assert property (@(posedge clk_i) disable iff (rst_i)
                                    (state_q == ARB_IDLE) |-> (req_ready_o == '0));

endmodule

// File: tb/tb_rr_pkt_arb.sv
// Bench for rr_pkt_arb: directed vector table, then random traffic against an
// integer-level round-robin model plus starvation/interleave scoreboarding.
module tb_rr_pkt_arb;

   localparam int N = 8;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [N-1:0] req_valid_i;
   logic [N-1:0] req_last_i;
   logic [N-1:0] req_mask_i;
   logic [N-1:0] req_ready_o;
   logic         gnt_valid_o;
   logic [N-1:0] gnt_oh_o;
   logic [2:0]   gnt_idx_o;
   logic         gnt_ready_i;

   rr_pkt_arb #(.NUM_REQ(N)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_last_i  (req_last_i),
      .req_mask_i  (req_mask_i),
      .req_ready_o (req_ready_o),
      .gnt_valid_o (gnt_valid_o),
      .gnt_oh_o    (gnt_oh_o),
      .gnt_idx_o   (gnt_idx_o),
      .gnt_ready_i (gnt_ready_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic         rst;
      logic [N-1:0] v;
      logic [N-1:0] l;
      logic [N-1:0] m;
      logic         g;
      logic         gv;
      logic [N-1:0] oh;
      logic [2:0]   idx;
      logic [N-1:0] rdy;
      logic [N-1:0] pri;
   } vec_t;

   vec_t tbl[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: owner index (-1 = none) and priority start index.
   int m_owner = -1;
   int m_pri   = 0;

   int obs_cur = -1;
   int waits[N];
   int max_wait = 0;
   int n_inter = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [N-1:0] oh_of(input int o);
      logic [N-1:0] r;
      r = '0;
      if (o >= 0) r[o] = 1'b1;
      return r;
   endfunction

   function automatic int pick(input logic [N-1:0] el, input int start, input int excl);
      for (int k = 0; k < N; k++) begin
         int c;
         c = (start + k) % N;
         if (el[c] && c != excl) return c;
      end
      return -1;
   endfunction

   task automatic drive(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic [N-1:0] m, input logic g);
      rst_i       = r;
      req_valid_i = v;
      req_last_i  = l;
      req_mask_i  = m;
      gnt_ready_i = g;
   endtask

   task automatic model_check();
      logic [N-1:0] e_rdy;
      logic         e_gv;
      e_rdy = '0;
      e_gv  = 1'b0;
      if (m_owner >= 0 && !rst_i) begin
         if (gnt_ready_i) e_rdy = oh_of(m_owner);
         e_gv = req_valid_i[m_owner];
      end
      chk("model_gnt_valid", 32'(gnt_valid_o), 32'(e_gv));
      chk("model_gnt_oh", 32'(gnt_oh_o), 32'(oh_of(m_owner)));
      chk("model_gnt_idx", 32'(gnt_idx_o), (m_owner < 0) ? 32'd0 : 32'(m_owner));
      chk("model_ready", 32'(req_ready_o), 32'(e_rdy));
      chk("model_pri", 32'(dut.pri_q), 32'(oh_of(m_pri)));
   endtask

   task automatic observe();
      logic [N-1:0] xf;
      logic [N-1:0] el;
      xf = req_valid_i & req_ready_o;
      el = req_valid_i & req_mask_i;
      if (rst_i) begin
         obs_cur = -1;
         for (int i = 0; i < N; i++) waits[i] = 0;
      end else begin
         for (int i = 0; i < N; i++)
            if (!el[i] || gnt_oh_o[i]) waits[i] = 0;
         for (int k = 0; k < N; k++) begin
            if (xf[k]) begin
               if (obs_cur >= 0 && obs_cur != k) n_inter++;
               if (req_last_i[k]) begin
                  obs_cur = -1;
                  for (int i = 0; i < N; i++) begin
                     if (i != k && el[i]) begin
                        waits[i]++;
                        if (waits[i] > max_wait) max_wait = waits[i];
                     end
                  end
               end else begin
                  obs_cur = k;
               end
            end
         end
      end
   endtask

   task automatic tick();
      logic [N-1:0] el;
      @(posedge clk_i);
      el = req_valid_i & req_mask_i;
      if (rst_i) begin
         m_owner = -1;
         m_pri   = 0;
      end else if (m_owner < 0) begin
         m_owner = pick(el, m_pri, -1);
      end else if (gnt_ready_i && req_valid_i[m_owner] && req_last_i[m_owner]) begin
         m_pri   = (m_owner + 1) % N;
         m_owner = pick(el, m_pri, m_owner);
      end
      cyc++;
      @(negedge clk_i);
   endtask

   task automatic add(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic [N-1:0] m, input logic g, input logic gv,
                      input logic [N-1:0] oh, input logic [2:0] idx,
                      input logic [N-1:0] rdy, input logic [N-1:0] pri);
      vec_t e;
      e.rst = r; e.v = v; e.l = l; e.m = m; e.g = g;
      e.gv = gv; e.oh = oh; e.idx = idx; e.rdy = rdy; e.pri = pri;
      tbl.push_back(e);
   endtask

   initial begin
      for (int i = 0; i < N; i++) waits[i] = 0;

      //   rst  valid  last   mask   g   gv  oh     idx   ready  pri
      add(1, 8'h00, 8'h00, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h01);
      // two single-beat packets, zero bubble
      add(0, 8'h24, 8'h24, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h01);
      add(0, 8'h24, 8'h24, 8'hFF, 1, 1, 8'h04, 3'd2, 8'h04, 8'h01);
      add(0, 8'h20, 8'h20, 8'hFF, 1, 1, 8'h20, 3'd5, 8'h20, 8'h08);
      add(0, 8'h00, 8'h00, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h40);
      // move pointer to 7, then wrap to 0 and 1
      add(0, 8'h40, 8'h40, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h40);
      add(0, 8'h40, 8'h40, 8'hFF, 1, 1, 8'h40, 3'd6, 8'h40, 8'h40);
      add(0, 8'h03, 8'h03, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h80);
      add(0, 8'h03, 8'h03, 8'hFF, 1, 1, 8'h01, 3'd0, 8'h01, 8'h80);
      add(0, 8'h02, 8'h02, 8'hFF, 1, 1, 8'h02, 3'd1, 8'h02, 8'h02);
      // sole requester 7: grant, bubble, grant
      add(0, 8'h80, 8'h80, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h04);
      add(0, 8'h80, 8'h80, 8'hFF, 1, 1, 8'h80, 3'd7, 8'h80, 8'h04);
      add(0, 8'h80, 8'h80, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h01);
      add(0, 8'h80, 8'h80, 8'hFF, 1, 1, 8'h80, 3'd7, 8'h80, 8'h01);
      // masked-out requester never wins
      add(0, 8'h01, 8'h01, 8'hFE, 1, 0, 8'h00, 3'd0, 8'h00, 8'h01);
      add(0, 8'h01, 8'h01, 8'hFE, 1, 0, 8'h00, 3'd0, 8'h00, 8'h01);
      // owner 3 four-beat packet, ready 1,0,1,1,1, requester 6 waiting
      add(0, 8'h48, 8'h00, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h01);
      add(0, 8'h48, 8'h00, 8'hFF, 1, 1, 8'h08, 3'd3, 8'h08, 8'h01);
      add(0, 8'h48, 8'h00, 8'hFF, 0, 1, 8'h08, 3'd3, 8'h00, 8'h01);
      add(0, 8'h48, 8'h00, 8'hFF, 1, 1, 8'h08, 3'd3, 8'h08, 8'h01);
      add(0, 8'h48, 8'h00, 8'hFF, 1, 1, 8'h08, 3'd3, 8'h08, 8'h01);
      add(0, 8'h48, 8'h08, 8'hFF, 1, 1, 8'h08, 3'd3, 8'h08, 8'h01);
      add(0, 8'h40, 8'h40, 8'hFF, 1, 1, 8'h40, 3'd6, 8'h40, 8'h10);
      // mask the owner mid-packet: lock held
      add(0, 8'h02, 8'h00, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h80);
      add(0, 8'h02, 8'h00, 8'hFD, 1, 1, 8'h02, 3'd1, 8'h02, 8'h80);
      add(0, 8'h02, 8'h02, 8'hFD, 1, 1, 8'h02, 3'd1, 8'h02, 8'h80);
      add(0, 8'h00, 8'h00, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h04);
      // owner 5 drops valid mid-packet: locked, 0 not served
      add(0, 8'h20, 8'h00, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h04);
      add(0, 8'h21, 8'h00, 8'hFF, 1, 1, 8'h20, 3'd5, 8'h20, 8'h04);
      add(0, 8'h01, 8'h00, 8'hFF, 1, 0, 8'h20, 3'd5, 8'h20, 8'h04);
      add(0, 8'h21, 8'h20, 8'hFF, 1, 1, 8'h20, 3'd5, 8'h20, 8'h04);
      add(0, 8'h01, 8'h01, 8'hFF, 1, 1, 8'h01, 3'd0, 8'h01, 8'h40);
      // reset during beat 2 of a 3-beat packet
      add(0, 8'h01, 8'h00, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h02);
      add(0, 8'h01, 8'h00, 8'hFF, 1, 1, 8'h01, 3'd0, 8'h01, 8'h02);
      add(1, 8'h01, 8'h00, 8'hFF, 1, 0, 8'h01, 3'd0, 8'h00, 8'h02);
      add(0, 8'h03, 8'h00, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h01);
      add(0, 8'h03, 8'h00, 8'hFF, 1, 1, 8'h01, 3'd0, 8'h01, 8'h01);
      add(0, 8'h03, 8'h01, 8'hFF, 1, 1, 8'h01, 3'd0, 8'h01, 8'h01);
      add(0, 8'h02, 8'h02, 8'hFF, 1, 1, 8'h02, 3'd1, 8'h02, 8'h02);
      add(0, 8'h00, 8'h00, 8'hFF, 1, 0, 8'h00, 3'd0, 8'h00, 8'h04);

      drive(1'b1, '0, '0, 8'hFF, 1'b1);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      m_owner = -1;
      m_pri   = 0;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].m, tbl[i].g);
         #1;
         chk($sformatf("row%0d_gnt_valid", i), 32'(gnt_valid_o), 32'(tbl[i].gv));
         chk($sformatf("row%0d_gnt_oh", i), 32'(gnt_oh_o), 32'(tbl[i].oh));
         chk($sformatf("row%0d_gnt_idx", i), 32'(gnt_idx_o), 32'(tbl[i].idx));
         chk($sformatf("row%0d_ready", i), 32'(req_ready_o), 32'(tbl[i].rdy));
         chk($sformatf("row%0d_pri", i), 32'(dut.pri_q), 32'(tbl[i].pri));
         model_check();
         observe();
         tick();
      end

      for (int c = 0; c < 10000; c++) begin
         logic [N-1:0] v;
         logic [N-1:0] l;
         logic [N-1:0] m;
         v = N'($urandom);
         l = '0;
         for (int b = 0; b < N; b++) l[b] = ($urandom_range(0, 9) < 3);
         m = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
         drive(($urandom_range(0, 1999) == 0), v, l, m, ($urandom_range(0, 3) != 0));
         #1;
         model_check();
         observe();
         tick();
         if (n_err > 50) break;
      end

      chk("interleaved_packets", 32'(n_inter), 32'd0);
      chk("starvation_bound", 32'(max_wait <= N), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
